// File: rtl/write_back_stage_pkg.sv
// Shared pipeline definitions: load-size encodings and the default
// link-register index. Used by decode, memory and write-back stages.
package write_back_stage_pkg;

  typedef enum logic [1:0] {
    LOAD_BYTE   = 2'b00,
    LOAD_HALF   = 2'b01,
    LOAD_WORD   = 2'b10,
    LOAD_WORD_X = 2'b11   // reserved encoding, behaves as a word load
  } load_size_t;

  localparam int DEFAULT_LINK_REGISTER = 31;

endpackage

// File: rtl/write_back_stage_if.sv
// Write-back stage bus.
//   master : MEM-side driver (drives i_*, observes o_*)
//   slave  : write_back_stage (reads i_*, drives o_*)
// o_retire_count exists only when WRITE_BACK_RETIRE_COUNT_EN is defined.
interface write_back_stage_if #(
  parameter int NB_DATA         = 32,
  parameter int NB_REG_ADDRESS  = 5,
  parameter int NB_RETIRE_COUNT = 32
);
  logic                      i_valid;
  logic                      i_stall;
  logic                      i_flush;
  logic                      i_reg_write;
  logic                      i_mem_to_reg;
  logic                      i_jump_link;
  logic                      i_link_to_fixed;
  logic [1:0]                i_load_size;
  logic                      i_load_unsigned;
  logic [1:0]                i_byte_offset;
  logic [NB_DATA-1:0]        i_data_from_memory;
  logic [NB_DATA-1:0]        i_alu_result;
  logic [NB_DATA-1:0]        i_link_address;
  logic [NB_REG_ADDRESS-1:0] i_dest_register;
  logic [NB_DATA-1:0]        o_data_write_back;
  logic [NB_REG_ADDRESS-1:0] o_address_write_back;
  logic                      o_reg_write;
  logic                      o_valid;
`ifdef WRITE_BACK_RETIRE_COUNT_EN
  logic [NB_RETIRE_COUNT-1:0] o_retire_count;
`endif

  modport master (
    output i_valid, i_stall, i_flush, i_reg_write, i_mem_to_reg, i_jump_link,
           i_link_to_fixed, i_load_size, i_load_unsigned, i_byte_offset,
           i_data_from_memory, i_alu_result, i_link_address, i_dest_register,
    input  o_data_write_back, o_address_write_back, o_reg_write, o_valid
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    , input o_retire_count
`endif
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_reg_write, i_mem_to_reg, i_jump_link,
           i_link_to_fixed, i_load_size, i_load_unsigned, i_byte_offset,
           i_data_from_memory, i_alu_result, i_link_address, i_dest_register,
    output o_data_write_back, o_address_write_back, o_reg_write, o_valid
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    , output o_retire_count
`endif
  );
endinterface

// File: rtl/write_back_stage_load_formatter.sv
// load_formatter: combinational little-endian load alignment.
//   raw_word     in  memory word
//   load_size    in  byte / half / word (11 = word)
//   load_unsigned in zero-extend when 1, else sign-extend
//   byte_offset  in  address bits [1:0]; half loads use bit 1 only
//   formatted    out aligned, extended result
// Requires NB_DATA >= 32.
module load_formatter
  import write_back_stage_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] raw_word,
  input  load_size_t         load_size,
  input  logic               load_unsigned,
  input  logic [1:0]         byte_offset,
  output logic [NB_DATA-1:0] formatted
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = raw_word[{byte_offset, 3'b000} +: 8];
  assign half_lane = raw_word[{byte_offset[1], 4'b0000} +: 16];

  always_comb begin
    formatted = raw_word;
    unique case (load_size)
      LOAD_BYTE: formatted = {{(NB_DATA-8){byte_lane[7] & ~load_unsigned}}, byte_lane};
      LOAD_HALF: formatted = {{(NB_DATA-16){half_lane[15] & ~load_unsigned}}, half_lane};
      default:   formatted = raw_word;
    endcase
  end
endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: selects write-back data (link / load / ALU), picks the
// destination register and registers both for one cycle of latency.
//   i_clock  : rising-edge clock
//   i_reset  : synchronous active-low reset
//   bus      : write_back_stage_if.slave (MEM-stage slot in, RF write out)
// Optional: WRITE_BACK_RETIRE_COUNT_EN adds a wrapping retire counter
// (bus.o_retire_count).
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int NB_DATA         = 32,
  parameter int NB_REG_ADDRESS  = 5,
  parameter int LINK_REGISTER   = DEFAULT_LINK_REGISTER,
  parameter int NB_RETIRE_COUNT = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  write_back_stage_if.slave  bus
);
  logic [NB_DATA-1:0]        load_data;
  logic [NB_DATA-1:0]        next_data;
  logic [NB_REG_ADDRESS-1:0] next_addr;
  logic                      next_we;
  logic                      capture;

  load_formatter #(.NB_DATA(NB_DATA)) u_load_formatter (
    .raw_word      (bus.i_data_from_memory),
    .load_size     (load_size_t'(bus.i_load_size)),
    .load_unsigned (bus.i_load_unsigned),
    .byte_offset   (bus.i_byte_offset),
    .formatted     (load_data)
  );

  always_comb begin
    if (bus.i_jump_link)       next_data = bus.i_link_address;
    else if (bus.i_mem_to_reg) next_data = load_data;
    else                       next_data = bus.i_alu_result;
  end

  assign next_addr = (bus.i_jump_link && bus.i_link_to_fixed)
                   ? NB_REG_ADDRESS'(LINK_REGISTER) : bus.i_dest_register;
  // r0 is hard-wired zero, so a write there is suppressed at capture.
  assign next_we   = bus.i_valid & bus.i_reg_write & (next_addr != '0);
  assign capture   = ~bus.i_stall & ~bus.i_flush;

  // Priority: reset > flush (bubble) > stall (hold) > capture.
  always_ff @(posedge i_clock) begin
    if (!i_reset || bus.i_flush) begin
      bus.o_data_write_back    <= '0;
      bus.o_address_write_back <= '0;
      bus.o_reg_write          <= 1'b0;
      bus.o_valid              <= 1'b0;
    end else if (capture) begin
      bus.o_data_write_back    <= next_data;
      bus.o_address_write_back <= next_addr;
      bus.o_reg_write          <= next_we;
      bus.o_valid              <= bus.i_valid;
    end
  end

`ifdef WRITE_BACK_RETIRE_COUNT_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset)
      bus.o_retire_count <= '0;
    else if (capture && bus.i_valid)
      bus.o_retire_count <= bus.o_retire_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int NB_RC   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  write_back_stage_if #(.NB_DATA(NB_DATA), .NB_REG_ADDRESS(NB_ADDR),
                        .NB_RETIRE_COUNT(NB_RC)) bus ();

  write_back_stage #(.NB_DATA(NB_DATA), .NB_REG_ADDRESS(NB_ADDR),
                     .LINK_REGISTER(31), .NB_RETIRE_COUNT(NB_RC)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic        valid, reg_write, mem_to_reg, jump_link, link_fixed;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] mem, alu, link;
    logic [4:0]  dest;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    logic        e_we, e_valid;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;   // retire count expected by the bench (mod 2^NB_RC)

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    bus.i_valid            = v.valid;
    bus.i_reg_write        = v.reg_write;
    bus.i_mem_to_reg       = v.mem_to_reg;
    bus.i_jump_link        = v.jump_link;
    bus.i_link_to_fixed    = v.link_fixed;
    bus.i_load_size        = v.size;
    bus.i_load_unsigned    = v.uns;
    bus.i_byte_offset      = v.off;
    bus.i_data_from_memory = v.mem;
    bus.i_alu_result       = v.alu;
    bus.i_link_address     = v.link;
    bus.i_dest_register    = v.dest;
  endtask

  // Edge, then sample at the falling edge; tracks the retire count.
  task automatic step();
    if (rst && bus.i_valid && !bus.i_stall && !bus.i_flush) exp_cnt = (exp_cnt + 1) % (1 << NB_RC);
    if (!rst) exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string name, input vec_t v);
    check({name, ".data"},  bus.o_data_write_back,    v.e_data);
    check({name, ".addr"},  bus.o_address_write_back, v.e_addr);
    check({name, ".we"},    bus.o_reg_write,          v.e_we);
    check({name, ".valid"}, bus.o_valid,              v.e_valid);
  endtask

  task automatic check_cnt(input string name);
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    check(name, bus.o_retire_count, exp_cnt);
`endif
  endtask

  // Reference model: spec rules with shifts/masks on a word.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic [31:0] ld, sh;
    sh = v.mem >> (8 * int'(v.off));
    if (v.size == 2'b00) begin
      ld = sh & 32'hFF;
      if (!v.uns && ld[7]) ld = ld | 32'hFFFF_FF00;
    end else if (v.size == 2'b01) begin
      ld = (v.mem >> (v.off[1] ? 16 : 0)) & 32'hFFFF;
      if (!v.uns && ld[15]) ld = ld | 32'hFFFF_0000;
    end else ld = v.mem;
    r.e_data  = v.jump_link ? v.link : (v.mem_to_reg ? ld : v.alu);
    r.e_addr  = (v.jump_link && v.link_fixed) ? 5'd31 : v.dest;
    r.e_valid = v.valid;
    r.e_we    = v.valid && v.reg_write && (r.e_addr != 0);
    return r;
  endfunction

  vec_t tbl[10];
  vec_t zero_v, a, b, rv;

  initial begin
    //          vld rw m2r jl lf sz    un off   mem           alu           link          dst   e_data        e_addr we vld
    tbl[0] = '{1,1,0,0,0,2'b10,0,2'd0,32'h8899_AABB,32'h0000_1234,32'h0,       5'd8, 32'h0000_1234,5'd8, 1,1};
    tbl[1] = '{1,1,1,0,0,2'b00,0,2'd2,32'h8899_AABB,32'h0,       32'h0,       5'd9, 32'hFFFF_FF99,5'd9, 1,1};
    tbl[2] = '{1,1,1,0,0,2'b00,1,2'd0,32'h8899_AABB,32'h0,       32'h0,       5'd9, 32'h0000_00BB,5'd9, 1,1};
    tbl[3] = '{1,1,1,0,0,2'b01,0,2'd2,32'h8899_AABB,32'h0,       32'h0,       5'd10,32'hFFFF_8899,5'd10,1,1};
    tbl[4] = '{1,1,1,0,0,2'b01,1,2'd0,32'h8899_AABB,32'h0,       32'h0,       5'd10,32'h0000_AABB,5'd10,1,1};
    tbl[5] = '{1,1,0,1,1,2'b10,0,2'd0,32'h0,       32'h5,       32'h0040_0008,5'd5, 32'h0040_0008,5'd31,1,1};
    tbl[6] = '{1,1,0,1,0,2'b10,0,2'd0,32'h0,       32'h5,       32'h0040_0008,5'd5, 32'h0040_0008,5'd5, 1,1};
    tbl[7] = '{1,1,0,0,0,2'b10,0,2'd0,32'h0,       32'hDEAD_0001,32'h0,       5'd0, 32'hDEAD_0001,5'd0, 0,1};
    tbl[8] = '{0,1,0,0,0,2'b10,0,2'd0,32'h0,       32'h0000_0077,32'h0,       5'd3, 32'h0000_0077,5'd3, 0,0};
    tbl[9] = '{1,1,1,0,0,2'b01,0,2'd3,32'h8899_AABB,32'h0,       32'h0,       5'd4, 32'hFFFF_8899,5'd4, 1,1};
    zero_v = '{0,0,0,0,0,2'b00,0,2'd0,32'h0,32'h0,32'h0,5'd0,32'h0,5'd0,0,0};

    // Reset state
    rst = 1'b0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    drive(tbl[0]);
    @(negedge clk); step();
    check_out("reset", zero_v);
    check_cnt("reset.cnt");
    rst = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      drive(tbl[i]); step();
      check_out($sformatf("vec%0d", i), tbl[i]);
    end
    check_cnt("table.cnt");

    // Stall three cycles, then flush while still stalled
    a = tbl[0]; b = tbl[5];
    drive(a); step();
    bus.i_stall = 1'b1; drive(b);
    for (int k = 0; k < 3; k++) begin
      step(); check_out($sformatf("stall%0d", k), a);
    end
    bus.i_flush = 1'b1; step();
    check_out("flush", zero_v);
    bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    check_cnt("stall.cnt");

    // Reset during a stalled valid slot
    drive(tbl[1]); step();
    bus.i_stall = 1'b1; bus.i_flush = 1'b1; rst = 1'b0; step();
    check_out("rst_mid", zero_v);
    check_cnt("rst_mid.cnt");
    rst = 1'b1; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    drive(zero_v); step();
    check("post_rst.we", bus.o_reg_write, 1'b0);

    // Retire counter: 17 valid captures plus non-counting cycles
    rst = 1'b0; step(); rst = 1'b1;
    drive(tbl[0]);
    for (int k = 0; k < 17; k++) step();
    bus.i_stall = 1'b1; step(); step();
    bus.i_flush = 1'b1; step();
    bus.i_stall = 1'b0; step();
    bus.i_flush = 1'b0; drive(tbl[8]); step(); step();
`ifdef WRITE_BACK_RETIRE_COUNT_EN
    check("retire17", bus.o_retire_count, 4'd1);
`endif
    check_cnt("retire17.model");

    // Randomized against the reference model
    for (int k = 0; k < 300; k++) begin
      rv.valid      = 1'($urandom);
      rv.reg_write  = 1'($urandom);
      rv.mem_to_reg = 1'($urandom);
      rv.jump_link  = ($urandom_range(0, 3) == 0);
      rv.link_fixed = 1'($urandom);
      rv.size       = 2'($urandom);
      rv.uns        = 1'($urandom);
      rv.off        = 2'($urandom);
      rv.mem        = $urandom;
      rv.alu        = $urandom;
      rv.link       = $urandom;
      rv.dest       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rv = model(rv);
      drive(rv); step();
      check_out($sformatf("rnd%0d", k), rv);
    end
    check_cnt("rnd.cnt");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 The block SHALL expose parameter NB_DATA, default 32, register-file data width.
REQ-002 The block SHALL expose parameter NB_REG_ADDRESS, default 5, register-file address width.
REQ-003 The block SHALL expose parameter LINK_REGISTER, default 31, destination index for JAL-style links.
REQ-004 The block SHALL expose parameter NB_RETIRE_COUNT, default 32, retire counter width.
REQ-005 The block SHALL have these ports:
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  MEM-stage slot holds a real instruction.
- i_stall  in  1  hold pipeline register.
- i_flush  in  1  replace captured slot with bubble.
- i_reg_write  in  1  instruction writes the register file.
- i_mem_to_reg  in  1  select load data.
- i_jump_link  in  1  select link address.
- i_link_to_fixed  in  1  with i_jump_link: destination is LINK_REGISTER.
- i_load_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- i_load_unsigned  in  1  zero-extend (else sign-extend).
- i_byte_offset  in  2  effective address bits [1:0].
- i_data_from_memory  in  NB_DATA  raw memory word.
- i_alu_result  in  NB_DATA  execute result.
- i_link_address  in  NB_DATA  return address (PC+8).
- i_dest_register  in  NB_REG_ADDRESS  rd/rt destination.
- o_data_write_back  out  NB_DATA  register-file write data.
- o_address_write_back  out  NB_REG_ADDRESS  register-file write address.
- o_reg_write  out  1  register-file write enable.
- o_valid  out  1  retired slot valid.
- o_retire_count  out  NB_RETIRE_COUNT  present only with macro (REQ-021).

Function
REQ-006 Data select SHALL be: i_jump_link -> i_link_address; else i_mem_to_reg -> formatted load; else i_alu_result.
REQ-007 Load formatting SHALL be little-endian: byte lane = i_byte_offset (offset 0 -> bits [7:0]); half lane = i_byte_offset[1] (bit 0 ignored); word passes unchanged.
REQ-008 Byte/half results SHALL be sign-extended to NB_DATA unless i_load_unsigned = 1, then zero-extended.
REQ-009 Address SHALL be LINK_REGISTER when i_jump_link & i_link_to_fixed, else i_dest_register.
REQ-010 Select, formatting and address SHALL be computed combinationally on inputs and captured in one pipeline register; all outputs SHALL come from that register (latency exactly 1 cycle).
REQ-011 Capture SHALL occur on every rising edge with i_reset = 1 and i_stall = 0.
REQ-012 With i_stall = 1 and i_flush = 0 the register SHALL hold all contents.
REQ-013 With i_flush = 1 the register SHALL load a bubble (o_valid = 0, o_reg_write = 0, data/address = 0) regardless of i_stall.
REQ-014 o_reg_write SHALL equal captured i_valid & i_reg_write & (address != 0); writes to register 0 SHALL never be asserted.
REQ-015 o_valid SHALL equal captured i_valid; invalid slots SHALL never assert o_reg_write.

Reset
REQ-016 When i_reset = 0 at a rising edge, all outputs SHALL become 0 next cycle, including o_retire_count.
REQ-017 Reset SHALL override i_stall and i_flush.
REQ-018 Reset asserted mid-operation SHALL discard the held slot; no write SHALL issue in the cycle after reset.

Configuration
REQ-019 Macro WRITE_BACK_RETIRE_COUNT_EN SHALL control a retire counter.
REQ-020 Defined: counter SHALL increment by 1 on each edge where a valid, non-flushed slot is captured (i_valid & ~i_stall & ~i_flush), wrapping modulo 2^NB_RETIRE_COUNT.
REQ-021 Defined: o_retire_count SHALL be present; undefined: port and counter SHALL be absent, all other behaviour identical.

Structure
REQ-022 Load-size encodings and LINK_REGISTER default SHALL live in a shared package used by decode, memory and this stage.
REQ-023 Load formatting (REQ-007/008) SHALL be a sub-module load_formatter, purely combinational.

Verification
REQ-024 ALU path: i_alu_result=0x0000_1234, dest=8, reg_write=1, valid=1 -> next cycle data 0x0000_1234, address 8, o_reg_write=1.
REQ-025 Loads from 0x8899_AABB: byte offset 2 signed -> 0xFFFF_FF99; byte offset 0 unsigned -> 0x0000_00BB; half offset 2 signed -> 0xFFFF_8899; half offset 0 unsigned -> 0x0000_AABB.
REQ-026 JAL: jump_link=1, link_to_fixed=1, link=0x0040_0008, dest=5 -> address 31, data 0x0040_0008; JALR with link_to_fixed=0 -> address 5.
REQ-027 Stall 3 cycles then flush with stall still high -> outputs held 3 cycles, then bubble (o_valid=0, o_reg_write=0).
REQ-028 dest=0, reg_write=1, valid=1 -> o_reg_write=0, o_valid=1; reset low during stalled valid slot -> all outputs 0 next cycle.
REQ-029 Macro defined, NB_RETIRE_COUNT=4: 17 valid captures -> o_retire_count=1; stalled, flushed and invalid cycles SHALL not count.
